// File: rtl/manchester_pkg.sv
// Shared definitions for the Manchester serial transmitter/receiver pair.
package manchester_pkg;

    localparam int   MANCH_DATA_BITS  = 8;
    localparam logic MANCH_IDLE_LEVEL = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        SEEK,
        TAIL
    } manch_state_e;

endpackage

// File: rtl/axis_byte_fifo.sv
// Byte FIFO with a registered AXI-Stream master side; the output register
// always mirrors the head entry so tdata holds steady under backpressure.
module axis_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       push,
    input  logic [7:0] push_data,
    output logic       full,
    output logic       m_axis_tvalid,
    output logic [7:0] m_axis_tdata,
    input  logic       m_axis_tready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [CNT_W-1:0] count, count_n;
    logic             pop, wr_en;
    logic [7:0]       head_n;

    assign full  = (count == CNT_W'(DEPTH));
    assign pop   = m_axis_tvalid && m_axis_tready;
    assign wr_en = push && (!full || pop);

    always_comb begin
        rd_ptr_n = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_n  = count + CNT_W'(wr_en) - CNT_W'(pop);
        // Nothing left behind the pop: the incoming byte becomes the head.
        if (count == CNT_W'(pop))
            head_n = push_data;
        else
            head_n = mem[rd_ptr_n];
    end

    always_ff @(posedge aclk) begin
        if (wr_en)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr        <= rd_ptr_n;
            count         <= count_n;
            m_axis_tvalid <= (count_n != '0);
            if (count_n != '0)
                m_axis_tdata <= head_n;
        end
    end

endmodule

// File: rtl/manchester_serial_rx.sv
// Manchester line receiver: mid-bit edge tracking with a skip/seek window,
// recovered bytes delivered on AXI-Stream through axis_byte_fifo.
module manchester_serial_rx
    import manchester_pkg::*;
#(
    parameter int HALF_BIT   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       serial_in,
    output logic       m_axis_tvalid,
    output logic [7:0] m_axis_tdata,
    input  logic       m_axis_tready,
    output logic       frame_err,
    output logic       overflow
);

    localparam int CNT_W = $clog2(2*HALF_BIT) + 1;
    localparam logic [CNT_W-1:0] SKIP_LOAD = CNT_W'(3*HALF_BIT/2 - 1);
    localparam logic [CNT_W-1:0] SEEK_LOAD = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(2*HALF_BIT - 1);
    localparam logic [3:0]       LAST_BIT  = 4'(MANCH_DATA_BITS - 1);

    logic sync_q1, sync_q2, line_prev, line, edge_det;
    manch_state_e state, state_n;
    logic [CNT_W-1:0]           cnt;
    logic [3:0]                 bit_cnt;
    logic [MANCH_DATA_BITS-1:0] shreg;
    logic push_q, fifo_full, pop;
    logic start_c, load_skip_c, load_seek_c, clr_cnt_c, inc_c, dec_c;
    logic shift_c, push_c, err_c;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sync_q1   <= MANCH_IDLE_LEVEL;
            sync_q2   <= MANCH_IDLE_LEVEL;
            line_prev <= MANCH_IDLE_LEVEL;
        end else begin
            sync_q1   <= serial_in;
            sync_q2   <= sync_q1;
            line_prev <= sync_q2;
        end
    end

    assign line     = sync_q2;
    assign edge_det = line ^ line_prev;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (edge_det && line) state_n = SKIP;
            SKIP: if (cnt == '0) state_n = SEEK;
            SEEK: begin
                if (edge_det)
                    state_n = (bit_cnt == LAST_BIT) ? TAIL : SKIP;
                else if (cnt == '0)
                    state_n = TAIL;
            end
            TAIL: if (!line && cnt == TAIL_LAST) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        start_c     = 1'b0;
        load_skip_c = 1'b0;
        load_seek_c = 1'b0;
        clr_cnt_c   = 1'b0;
        inc_c       = 1'b0;
        dec_c       = 1'b0;
        shift_c     = 1'b0;
        push_c      = 1'b0;
        err_c       = 1'b0;
        case (state)
            IDLE: begin
                // Falling edges on an idle line are ignored.
                start_c     = edge_det && line;
                load_skip_c = edge_det && line;
            end
            SKIP: begin
                load_seek_c = (cnt == '0);
                dec_c       = (cnt != '0);
            end
            SEEK: begin
                if (edge_det) begin
                    shift_c     = 1'b1;
                    push_c      = (bit_cnt == LAST_BIT);
                    load_skip_c = (bit_cnt != LAST_BIT);
                    clr_cnt_c   = (bit_cnt == LAST_BIT);
                end else begin
                    err_c     = (cnt == '0);
                    clr_cnt_c = (cnt == '0);
                    dec_c     = (cnt != '0);
                end
            end
            TAIL: begin
                // cnt counts consecutive low cycles; any high restarts it.
                clr_cnt_c = line;
                inc_c     = !line;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            push_q    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            push_q    <= push_c;
            frame_err <= err_c;
            if (load_skip_c)      cnt <= SKIP_LOAD;
            else if (load_seek_c) cnt <= SEEK_LOAD;
            else if (clr_cnt_c)   cnt <= '0;
            else if (inc_c)       cnt <= cnt + CNT_W'(1);
            else if (dec_c)       cnt <= cnt - CNT_W'(1);
            if (start_c) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (shift_c) begin
                bit_cnt <= bit_cnt + 4'd1;
                shreg   <= {shreg[MANCH_DATA_BITS-2:0], line};
            end
        end
    end

    assign pop = m_axis_tvalid && m_axis_tready;

    // A full FIFO still takes the byte when the head leaves in the same cycle.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) overflow <= 1'b0;
        else        overflow <= push_q && fifo_full && !pop;
    end

    axis_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk          (aclk),
        .areset        (areset),
        .push          (push_q),
        .push_data     (shreg),
        .full          (fifo_full),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tready (m_axis_tready)
    );

endmodule

// File: tb/tb_manchester_serial_rx.sv
// Scoreboard bench for manchester_serial_rx: a line-level Manchester encoder
// drives frames, expected bytes are queued and checked by a separate monitor.
module tb_manchester_serial_rx;

    localparam int H     = 4;
    localparam int DEPTH = 4;

    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic       serial_in = 1'b0;
    logic       m_axis_tready = 1'b1;
    logic       m_axis_tvalid, frame_err, overflow;
    logic [7:0] m_axis_tdata;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0, n_fail = 0;
    int   err_cnt = 0, ovf_cnt = 0, ovf_cyc = -1;
    bit   rand_ready = 1'b0;

    manchester_serial_rx #(.HALF_BIT(H), .FIFO_DEPTH(DEPTH)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .serial_in     (serial_in),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tready (m_axis_tready),
        .frame_err     (frame_err),
        .overflow      (overflow)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Hold the line at lvl for n cycles; inputs change 1 time unit after the edge.
    task automatic hold(input logic lvl, input int n);
        serial_in = lvl;
        repeat (n) begin
            @(posedge aclk); #1;
            if (rand_ready) m_axis_tready = ($urandom_range(3) != 0);
        end
    endtask

    // mode: 0 = byte must be dropped, 1 = expected, 2 = expected with exact latency
    task automatic send_frame(input logic [7:0] b, input int gap, input int mode,
                              output int mid);
        logic [8:0] bits;
        exp_t       e;
        bits = {1'b1, b};
        mid  = -1;
        for (int i = 8; i >= 0; i--) begin
            hold(~bits[i], H);
            if (i == 0) begin
                mid = cyc;
                if (mode != 0) begin
                    e.data = b;
                    e.cyc  = (mode == 2) ? cyc + 4 : -1;
                    sb.push_back(e);
                end
            end
            hold(bits[i], H);
        end
        hold(1'b0, gap);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && sb.size() != 0; i++) begin
            @(posedge aclk); #1;
        end
        check(name, sb.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every handshake, tracks pulses and stalls.
    initial begin
        exp_t       e;
        bit         stalled = 1'b0;
        logic [7:0] held = '0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                stalled = 1'b0;
                continue;
            end
            if (frame_err) err_cnt++;
            if (overflow) begin
                ovf_cnt++;
                ovf_cyc = cyc;
            end
            if (frame_err || overflow)
                check("pulse_exclusive", int'(frame_err & overflow), 0);
            if (stalled) begin
                check("stall_tvalid_held", int'(m_axis_tvalid), 1);
                check("stall_tdata_held", int'(m_axis_tdata), int'(held));
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            held    = m_axis_tdata;
            if (m_axis_tvalid && m_axis_tready) begin
                check("beat_expected", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("beat_data", int'(m_axis_tdata), int'(e.data));
                    if (e.cyc >= 0) check("beat_latency", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int  mid, e0, o0, occ, exp_ovf;
        bit  keep;
        logic [7:0] b;
        exp_ovf = -1;

        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", int'(m_axis_tvalid), 0);
        check("rst_tdata", int'(m_axis_tdata), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overflow", int'(overflow), 0);
        areset = 1'b0;
        hold(1'b0, 10);

        // Single frame, exact latency.
        send_frame(8'hF0, 16, 2, mid);
        wait_drain("f0_drain");
        check("f0_no_err", err_cnt, 0);
        check("f0_no_ovf", ovf_cnt, 0);

        // Three frames at minimum gap.
        send_frame(8'hF0, 2*H, 2, mid);
        send_frame(8'h0F, 2*H, 2, mid);
        send_frame(8'hAA, 2*H, 2, mid);
        hold(1'b0, 16);
        wait_drain("b2b_drain");
        check("b2b_no_err", err_cnt, 0);

        // Stalled consumer: FIFO fills with four bytes, the fifth is dropped.
        m_axis_tready = 1'b0;
        o0  = ovf_cnt;
        occ = 0;
        for (int k = 1; k <= 5; k++) begin
            keep = (occ < DEPTH);
            if (keep) occ++;
            send_frame(8'(k), 2*H, keep ? 1 : 0, mid);
            if (!keep) exp_ovf = mid + 4;
        end
        hold(1'b0, 10);
        check("ovf_count", ovf_cnt - o0, 1);
        check("ovf_cycle", ovf_cyc, exp_ovf);
        check("ovf_head_tvalid", int'(m_axis_tvalid), 1);
        check("ovf_head_tdata", int'(m_axis_tdata), 1);
        m_axis_tready = 1'b1;
        wait_drain("ovf_drain");

        // Start bit plus three bits, then the line stays low.
        e0 = err_cnt;
        hold(1'b0, H);
        hold(1'b1, H);
        for (int i = 0; i < 3; i++) begin
            b[0] = 1'($urandom_range(1));
            hold(~b[0], H);
            hold(b[0], H);
        end
        hold(1'b0, 40);
        check("partial_err", err_cnt - e0, 1);
        send_frame(8'h55, 16, 2, mid);
        wait_drain("partial_follow_drain");
        check("partial_follow_err", err_cnt - e0, 1);

        // One-cycle glitch on the idle line.
        e0 = err_cnt;
        hold(1'b1, 1);
        hold(1'b0, 40);
        check("glitch_err", err_cnt - e0, 1);
        send_frame(8'hC3, 16, 2, mid);
        wait_drain("glitch_follow_drain");
        check("glitch_follow_err", err_cnt - e0, 1);

        // Reset mid-frame with two bytes waiting.
        m_axis_tready = 1'b0;
        e0 = err_cnt;
        send_frame(8'($urandom), 16, 1, mid);
        send_frame(8'($urandom), 16, 1, mid);
        check("pre_rst_tvalid", int'(m_axis_tvalid), 1);
        hold(1'b0, H);
        hold(1'b1, H);
        hold(1'b0, H);
        hold(1'b1, 2);
        areset    = 1'b1;
        serial_in = 1'b0;
        sb.delete();
        #1;
        check("rst_mid_tvalid", int'(m_axis_tvalid), 0);
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;
        hold(1'b0, 20);
        check("rst_fifo_empty", int'(m_axis_tvalid), 0);
        check("rst_no_err", err_cnt - e0, 0);
        m_axis_tready = 1'b1;
        send_frame(8'h3C, 16, 2, mid);
        wait_drain("rst_follow_drain");
        check("rst_follow_err", err_cnt - e0, 0);

        // Random bytes, random gaps, random consumer backpressure.
        e0 = err_cnt;
        o0 = ovf_cnt;
        rand_ready = 1'b1;
        for (int k = 0; k < 8; k++)
            send_frame(8'($urandom), 2*H + int'($urandom_range(10)), 1, mid);
        rand_ready    = 1'b0;
        m_axis_tready = 1'b1;
        wait_drain("rand_drain");
        check("rand_no_err", err_cnt - e0, 0);
        check("rand_no_ovf", ovf_cnt - o0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
